// File: rtl/tnew_scoreboard_if.sv
// D-stage hazard query bus: D-stage instruction fields in, stall/forwarding/md status out.
interface tnew_scoreboard_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TNEW_W = 2
);
  localparam int unsigned SEL_W = $clog2(STAGES + 1);

  logic              d_valid;
  logic [4:0]        d_wa;
  logic [TNEW_W-1:0] d_tnew;
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic              d_md_start;
  logic              d_md_use;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_wa, d_tnew, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_start, d_md_use,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_wa, d_tnew, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md_start, d_md_use,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/tnew_scoreboard.sv
// Tnew/Tuse hazard scoreboard beside the D stage: tracks in-flight writers, derives
// the D stall and operand forwarding selects, and times the multi-cycle mult/div unit.
module tnew_scoreboard #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned MD_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  tnew_scoreboard_if.slave sb
);
  localparam int unsigned SEL_W = $clog2(STAGES + 1);
  localparam int unsigned MD_W  = 4;

  typedef struct packed {
    logic              valid;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  entry_t            tbl [STAGES];
  logic [MD_W-1:0]   md_cnt;

  logic              rs_haz;
  logic              rt_haz;
  logic [SEL_W-1:0]  rs_sel;
  logic [SEL_W-1:0]  rt_sel;
  logic              rs_used;
  logic              rt_used;
  logic              md_busy_c;
  logic              stall_c;

  // Youngest-match lookup: scan oldest to youngest so the lowest index wins.
  always_comb begin
    rs_haz  = 1'b0;
    rt_haz  = 1'b0;
    rs_sel  = '0;
    rt_sel  = '0;
    rs_used = (sb.d_rs != 5'd0) && (sb.d_tuse_rs != '1);
    rt_used = (sb.d_rt != 5'd0) && (sb.d_tuse_rt != '1);
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (rs_used && tbl[k].valid && (tbl[k].wa == sb.d_rs)) begin
        rs_haz = (tbl[k].tnew > sb.d_tuse_rs);
        rs_sel = (tbl[k].tnew == '0) ? SEL_W'(k + 1) : '0;
      end
      if (rt_used && tbl[k].valid && (tbl[k].wa == sb.d_rt)) begin
        rt_haz = (tbl[k].tnew > sb.d_tuse_rt);
        rt_sel = (tbl[k].tnew == '0) ? SEL_W'(k + 1) : '0;
      end
    end
  end

  assign md_busy_c = (md_cnt != '0);
  assign stall_c   = sb.d_valid & (rs_haz | rt_haz | (sb.d_md_use & md_busy_c));

  assign sb.stall      = stall_c;
  assign sb.fwd_rs_sel = rs_sel;
  assign sb.fwd_rt_sel = rt_sel;
  assign sb.md_busy    = md_busy_c;

  // Table shift: downstream stages always advance; a stall only bubbles entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        tbl[i] <= '0;
      end
      md_cnt <= '0;
    end else begin
      if (sb.d_valid && !stall_c) begin
        tbl[0] <= '{valid: 1'b1, wa: sb.d_wa, tnew: sb.d_tnew};
      end else begin
        tbl[0] <= '0;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        tbl[i].valid <= tbl[i-1].valid;
        tbl[i].wa    <= tbl[i-1].wa;
        tbl[i].tnew  <= (tbl[i-1].tnew == '0) ? '0 : tbl[i-1].tnew - TNEW_W'(1);
      end
      if (sb.d_valid && sb.d_md_start && !stall_c) begin
        md_cnt <= MD_W'(MD_LAT);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - MD_W'(1);
      end
    end
  end
endmodule

// File: doc/tnew_scoreboard.md
# tnew_scoreboard

Parametrised Tnew/Tuse hazard scoreboard for the pipelined MIPS core. It sits beside the D stage. Every instruction leaving D is recorded with its destination register and Tnew, and Tnew counts down as the instruction moves through a configurable number of downstream stages. Each cycle the block produces the D-stage stall and per-operand forwarding selects, and adds a latency counter for a multi-cycle mult/div unit.

## Interface

Parameters:
- STAGES, 3, number of tracked stages after D (entry 0 = E, 1 = M, 2 = W, ...).
- TNEW_W, 2, width of Tnew and Tuse fields.
- MD_LAT, 5, busy cycles of the mult/div unit after issue; must fit in 4 bits (1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- d_valid  in  1  D holds a real instruction; 0 = bubble.
- d_wa  in  5  destination register of D instruction; 0 = no GPR write.
- d_tnew  in  TNEW_W  cycles after entering E until result exists.
- d_rs, d_rt  in  5 each  source registers read by the D instruction.
- d_tuse_rs, d_tuse_rt  in  TNEW_W each  cycles until the operand is consumed; all-ones = operand not read.
- d_md_start  in  1  D instruction starts mult/div.
- d_md_use  in  1  D instruction touches HI/LO or the md unit (includes starts).
- stall  out  1  freeze PC and F/D; insert bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  $clog2(STAGES+1) each  0 = register file; k = forward from entry k-1.
- md_busy  out  1  mult/div counter nonzero.

## Operation

- Per-entry state: valid, wa (5), tnew (TNEW_W).
- Every cycle, for i ≥ 1, entry[i] loads entry[i-1] with tnew decremented and saturating at 0. The last entry is dropped.
- Entry 0 on stall = 0 loads a bubble (valid 0) when d_valid = 0. Otherwise it loads {1, d_wa, d_tnew}.
- Entry 0 on stall = 1 loads a bubble. The downstream entries still advance, so stalls never freeze E/M/W.
- Match on operand r (rs or rt): r ≠ 0, the tuse field is not all-ones, and the entry is valid with entry.wa == r. If several entries match, the youngest (lowest index) wins.
- GPR hazard on r: the youngest match has tnew > tuse.
- fwd_r_sel = k+1 when the youngest match is entry k with tnew == 0. Otherwise fwd_r_sel = 0.
- mult/div counter (4 bits):
  - Loads MD_LAT when d_valid & d_md_start & ~stall.
  - Otherwise decrements when nonzero.
  - md_busy = (count ≠ 0).
- MD hazard: d_valid & d_md_use & md_busy.
- stall = d_valid & (GPR hazard on rs | GPR hazard on rt | MD hazard).
- stall, fwd_*_sel and md_busy are combinational from the D inputs and registered state. There are no registered outputs.

## Timing

- Reset, applied at the clock edge, clears all entries to invalid and the counter to 0. With all entries invalid, stall = 0, fwd selects = 0 and md_busy = 0 in the following cycle.
- Reset mid-operation discards all in-flight entries and any md count. Reset takes priority over issue in the same cycle.
- Tnew decreases by exactly 1 per stage advanced. A result with d_tnew = t becomes forwardable (tnew = 0) once it reaches entry t.
- A producer with d_tnew ≥ STAGES is never forwardable. A consumer depending on it stalls until the entry drops off the end of the table.
- Register 0 never matches, never stalls and never forwards.
- md start issued in cycle n: md_busy is high in cycles n+1 .. n+MD_LAT.
- A second md_start arriving while md_busy is high is stalled, because d_md_use is 1. The counter is not reloaded.
- Stall with d_valid = 0 is impossible (stall is forced low).

## Test plan

- Reset: hold reset 2 cycles with d_valid = 1, d_rs = 5 -> stall = 0, fwd_rs_sel = 0, md_busy = 0. Cycle after release: table empty, no match.
- lw-use: issue d_wa = 8, d_tnew = 2. Next cycle d_rs = 8, d_tuse_rs = 0 -> stall = 1 for 2 cycles. Then stall = 0, fwd_rs_sel = 3 (entry 2, W).
- ALU chain: issue d_wa = 9, d_tnew = 1, then d_rt = 9, d_tuse_rt = 1 -> stall = 0, fwd_rt_sel = 0. One cycle later the producer sits in entry 1 with tnew = 0 -> fwd_rt_sel = 2.
- Youngest wins: issue two writers to $4, the older with tnew 0 and the younger with tnew 1. Consumer tuse 0 -> stall = 1. No forwarding from the older entry.
- $0 and unused operand: d_rs = 0 while a valid entry has wa = 0; d_rt = 7 with d_tuse_rt = all-ones and a pending writer to $7 -> stall = 0, fwd selects 0.
- MD: issue d_md_start in cycle 10 with MD_LAT = 5 -> md_busy high in cycles 11–15. d_md_use in cycle 12 -> stall = 1 through cycle 15 and released in cycle 16.
